serial_sub32: RTL

- Bit-serial two's-complement subtractor. Computes diff = a - b, LSB first, with one full-subtractor cell and a borrow flop.
- Area-light counterpart to the combinational ripple adder/subtractor. Used where a WIDTH-cycle latency is acceptable.
- Produces the result, the final borrow (unsigned a < b) and signed overflow, using a start/busy/done handshake.

---
 rtl/serial_sub32_pkg.sv | 15 +
 rtl/serial_sub32_fs.sv | 20 ++
 rtl/serial_sub32.sv | 119 +++++++++++
 3 files changed

// File: rtl/serial_sub32_pkg.sv
// serial_sub32_pkg
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the default operand/counter widths.
package serial_sub32_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CW    = 6;

endpackage

// File: rtl/serial_sub32_fs.sv
// serial_sub32_fs
// One-bit full subtractor cell: computes i_a - i_b - i_bin.
// Ports:
//   i_a    minuend bit
//   i_b    subtrahend bit
//   i_bin  borrow in
//   o_diff difference bit
//   o_bo   borrow out
module serial_sub32_fs (
  input  logic i_a,
  input  logic i_b,
  input  logic i_bin,
  output logic o_diff,
  output logic o_bo
);

  assign o_diff = i_a ^ i_b ^ i_bin;
  assign o_bo   = (~i_a & i_b) | (~(i_a ^ i_b) & i_bin);

endmodule

// File: rtl/serial_sub32.sv
// serial_sub32
// Bit-serial two's-complement subtractor, diff = a - b, processed LSB first
// through a single full-subtractor cell and a borrow flop. One result every
// WIDTH+1 cycles using a start/busy/done handshake.
//
// WIDTH must be at least 2 and CW must satisfy 2**CW > WIDTH.
//
// State table
//   ST_IDLE | waiting for start
//   ST_RUN  | shifting one bit per cycle through the FS cell
//   ST_DONE | result valid, done high; start here chains a new operation
//
// Ports:
//   i_clk   clock, rising edge
//   i_rst   asynchronous active-high reset
//   i_start request, sampled only when not busy
//   i_a     minuend, sampled on the accepting edge
//   i_b     subtrahend, sampled on the accepting edge
//   o_busy  operation in progress
//   o_done  one-cycle completion pulse
//   o_diff  registered result, held until the next completion
//   o_bout  final borrow (unsigned a < b)
//   o_ovf   signed overflow of a - b
module serial_sub32
  import serial_sub32_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CW    = DEF_CW
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_bout,
  output logic             o_ovf
);

  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_br;
  logic [CW-1:0]    r_cnt;

  logic w_d;
  logic w_bo;

  serial_sub32_fs u_fs (
    .i_a    (r_a[0]),
    .i_b    (r_b[0]),
    .i_bin  (r_br),
    .o_diff (w_d),
    .o_bo   (w_bo)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_br    <= 1'b0;
      r_cnt   <= '0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
      o_diff  <= '0;
      o_bout  <= 1'b0;
      o_ovf   <= 1'b0;
    end else begin
      case (r_state)
        // DONE behaves like IDLE for acceptance, which gives back-to-back
        // operation without an idle gap.
        ST_IDLE, ST_DONE: begin
          o_done <= 1'b0;
          if (i_start) begin
            r_a     <= i_a;
            r_b     <= i_b;
            r_res   <= '0;
            r_br    <= 1'b0;
            r_cnt   <= '0;
            o_busy  <= 1'b1;
            r_state <= ST_RUN;
          end else begin
            r_state <= ST_IDLE;
          end
        end

        ST_RUN: begin
          r_res <= {w_d, r_res[WIDTH-1:1]};
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_br  <= w_bo;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == LAST_BIT) begin
            // Last bit: r_a[0]/r_b[0] now hold the operand sign bits and
            // w_d is the result sign bit.
            o_diff  <= {w_d, r_res[WIDTH-1:1]};
            o_bout  <= w_bo;
            o_ovf   <= (r_a[0] ^ r_b[0]) & (w_d ^ r_a[0]);
            o_busy  <= 1'b0;
            o_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
